// File: rtl/wallace_pkg.sv
// Shared definitions for the Wallace multiplier pipeline: operand width,
// result-width helper and the resolver's stage-1 payload.
package wallace_pkg;

    localparam int WALLACE_W    = 8;
    localparam int WALLACE_LO_W = WALLACE_W / 2;
    localparam int WALLACE_HI_W = WALLACE_W - WALLACE_LO_W;

    function automatic int res_w(input int w);
        return w + 2;
    endfunction

    // Low half already resolved; high half still in carry-save form (weights LO_W..W).
    typedef struct packed {
        logic [WALLACE_LO_W-1:0] lo;
        logic                    c_lo;
        logic [WALLACE_HI_W-1:0] u_hi;
        logic [WALLACE_HI_W:0]   v_hi;
    } s1_payload_t;

endpackage

// File: rtl/cpa_slice.sv
// Parameterised ripple carry adder: N-bit a + b + cin -> N-bit sum and carry out.
module cpa_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        FullAdder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[N];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used by the ripple carry slices.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/csa_resolve_adder_pl.sv
// Two-stage carry-propagate resolver for the carry-save output of the Wallace tree.
// Optional registered zero flag on the result when CPA_ZERO_FLAG_EN is defined.
module csa_resolve_adder_pl
    import wallace_pkg::*;
#(
    parameter int WIDTH = WALLACE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_u,
    input  logic [WIDTH-1:0]        in_v,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef CPA_ZERO_FLAG_EN
    output logic                    out_zero,
`endif
    output logic [res_w(WIDTH)-1:0] out_sum
);

    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    s1_payload_t               s1_q, s1_d;
    logic                      s1_valid_q, s1_valid_d;
    logic                      out_valid_q, out_valid_d;
    logic [res_w(WIDTH)-1:0]   out_sum_q, out_sum_d;

    logic                      adv2;
    logic                      accept;
    logic [LO_W-1:0]           lo_sum;
    logic                      lo_cout;
    logic [HI_W:0]             hi_sum;
    logic                      hi_cout;

    // v is aligned one place up, so its low-half contribution drops the top v bit.
    cpa_slice #(.N(LO_W)) u_lo_slice (
        .a    (in_u[LO_W-1:0]),
        .b    ({in_v[LO_W-2:0], 1'b0}),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    cpa_slice #(.N(HI_W + 1)) u_hi_slice (
        .a    ({1'b0, s1_q.u_hi}),
        .b    (s1_q.v_hi),
        .cin  (s1_q.c_lo),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    always_comb begin
        adv2        = s1_valid_q && (!out_valid_q || out_ready);
        in_ready    = !s1_valid_q || adv2;
        accept      = in_valid && in_ready;

        s1_d        = s1_q;
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;

        if (accept) begin
            s1_d.lo    = lo_sum;
            s1_d.c_lo  = lo_cout;
            s1_d.u_hi  = in_u[WIDTH-1:LO_W];
            s1_d.v_hi  = in_v[WIDTH-1:LO_W-1];
            s1_valid_d = 1'b1;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end

        if (adv2) begin
            out_sum_d   = {hi_cout, hi_sum, s1_q.lo};
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

`ifdef CPA_ZERO_FLAG_EN
    logic lo_zero_q;
    logic out_zero_q;

    // Zero-ness of the low half is captured early so stage 2 only inspects the high sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_zero_q  <= 1'b0;
            out_zero_q <= 1'b0;
        end else begin
            if (accept) begin
                lo_zero_q <= (lo_sum == '0);
            end
            if (adv2) begin
                out_zero_q <= lo_zero_q && ({hi_cout, hi_sum} == '0);
            end
        end
    end

    assign out_zero = out_zero_q;
`endif

endmodule
